// File: rtl/mem_access.sv
// MEM pipeline stage: drives a req/ack data bus for loads and stores, formats load data,
// builds store byte lanes and holds the pipeline while an access is outstanding.
// Optional macro MEM_MISALIGN_CHK_EN rejects misaligned halfword/word accesses without a bus cycle.
module mem_access #(
   parameter int TIMEOUT = 16,
   parameter int TO_W    = 5
) (
   input  logic        clk_100MHz,
   input  logic        arst_n,
   input  logic        hold_ena_i,
   input  logic [31:0] inst_i,
   input  logic        mem_rena_i,
   input  logic        mem_wena_i,
   input  logic [31:0] mem_addr_i,
   input  logic [31:0] mem_wdata_i,
   input  logic        reg_wena_i,
   input  logic [31:0] reg_wdata_i,
   input  logic [4:0]  reg_waddr_i,
   output logic        bus_req_o,
   output logic        bus_we_o,
   output logic [31:0] bus_addr_o,
   output logic [31:0] bus_wdata_o,
   output logic [3:0]  bus_be_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i,
   output logic        hold_req_o,
   output logic        bus_err_o,
   output logic        misalign_o,
   output logic [31:0] inst_o,
   output logic        mem_rena_o,
   output logic [31:0] mem_rdata_o,
   output logic [31:0] mem_raddr_o,
   output logic        reg_wena_o,
   output logic [31:0] reg_wdata_o,
   output logic [4:0]  reg_waddr_o,
   output logic        mem_wena_o,
   output logic [31:0] mem_waddr_o,
   output logic [31:0] mem_wdata_o,
   output logic [1:0]  fsm_state
);

   // Bus handshake: bus_req_o rises with a stable payload and stays high, payload unchanged,
   // until the cycle bus_ack_i is sampled high (or the timeout fires); rdata is valid with ack.
   typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;

   state_t          state;
   logic [TO_W-1:0] cnt;
   logic [31:0]     ld_data;
   logic [31:0]     addr_q;
   logic [31:0]     wdata_q;
   logic [2:0]      f3_q;
   logic            is_load_q;
   logic            abort_q;

   logic [2:0]  f3;
   logic        start;
   logic        misaligned;
   logic        done;
   logic [3:0]  be_n;
   logic [31:0] wdata_n;
   logic [7:0]  lb;
   logic [15:0] lh;
   logic [31:0] ld_fmt;

   assign f3    = inst_i[14:12];
   assign start = (state == IDLE) && (mem_rena_i || mem_wena_i) && !hold_ena_i;
   assign done  = (state == DONE);

`ifdef MEM_MISALIGN_CHK_EN
   assign misaligned = ((f3[1:0] == 2'b01) && mem_addr_i[0]) ||
                       ((f3 == 3'b010) && (mem_addr_i[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   always_comb begin
      be_n    = 4'b1111;
      wdata_n = mem_wdata_i;
      case (f3[1:0])
         2'b00: begin
            be_n    = 4'b0001 << mem_addr_i[1:0];
            wdata_n = {4{mem_wdata_i[7:0]}};
         end
         2'b01: begin
            be_n    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
            wdata_n = {2{mem_wdata_i[15:0]}};
         end
         default: ;
      endcase
   end

   always_comb begin
      lb = bus_rdata_i[7:0];
      case (addr_q[1:0])
         2'd1:    lb = bus_rdata_i[15:8];
         2'd2:    lb = bus_rdata_i[23:16];
         2'd3:    lb = bus_rdata_i[31:24];
         default: ;
      endcase
      lh = addr_q[1] ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
      case (f3_q)
         3'b000:  ld_fmt = {{24{lb[7]}}, lb};
         3'b001:  ld_fmt = {{16{lh[15]}}, lh};
         3'b100:  ld_fmt = {24'h0, lb};
         3'b101:  ld_fmt = {16'h0, lh};
         default: ld_fmt = bus_rdata_i;
      endcase
   end

   always_ff @(posedge clk_100MHz or negedge arst_n) begin
      if (!arst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_wdata_o <= '0;
         bus_be_o    <= '0;
         bus_err_o   <= 1'b0;
         misalign_o  <= 1'b0;
         ld_data     <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         f3_q        <= '0;
         is_load_q   <= 1'b0;
         abort_q     <= 1'b0;
      end else begin
         bus_err_o  <= 1'b0;
         misalign_o <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  addr_q    <= mem_addr_i;
                  wdata_q   <= mem_wdata_i;
                  f3_q      <= f3;
                  is_load_q <= !mem_wena_i;
                  cnt       <= '0;
                  if (misaligned) begin
                     misalign_o <= 1'b1;
                     abort_q    <= 1'b1;
                     ld_data    <= '0;
                     state      <= DONE;
                  end else begin
                     abort_q     <= 1'b0;
                     bus_req_o   <= 1'b1;
                     bus_we_o    <= mem_wena_i;
                     bus_addr_o  <= {mem_addr_i[31:2], 2'b00};
                     bus_be_o    <= be_n;
                     bus_wdata_o <= wdata_n;
                     state       <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               // An ack in the final timeout cycle still completes the access.
               if (bus_ack_i) begin
                  bus_req_o <= 1'b0;
                  if (is_load_q) ld_data <= ld_fmt;
                  state <= DONE;
               end else if (cnt == TO_W'(TIMEOUT - 1)) begin
                  bus_req_o <= 1'b0;
                  bus_err_o <= 1'b1;
                  ld_data   <= '0;
                  abort_q   <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (!hold_ena_i) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign hold_req_o  = start || (state == ACCESS);
   assign fsm_state   = state;
   assign inst_o      = inst_i;
   assign mem_rena_o  = mem_rena_i;
   assign reg_waddr_o = reg_waddr_i;
   assign reg_wena_o  = reg_wena_i && !(done && abort_q);
   assign mem_wena_o  = mem_wena_i && !(done && abort_q);
   assign reg_wdata_o = (done && is_load_q) ? ld_data : reg_wdata_i;
   assign mem_rdata_o = ld_data;
   assign mem_raddr_o = done ? addr_q : mem_addr_i;
   assign mem_waddr_o = done ? addr_q : mem_addr_i;
   assign mem_wdata_o = done ? wdata_q : mem_wdata_i;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed and random loads/stores against a byte-lane reference model.
module tb_mem_access;

   localparam int TIMEOUT = 16;

   logic        clk_100MHz = 1'b0;
   logic        arst_n;
   logic        hold_ena;
   logic [31:0] inst;
   logic        mem_rena, mem_wena;
   logic [31:0] mem_addr, mem_wdata;
   logic        reg_wena;
   logic [31:0] reg_wdata;
   logic [4:0]  reg_waddr;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        hold_req, bus_err, misalign;
   logic [31:0] inst_o, mem_rdata_o, mem_raddr_o, reg_wdata_o, mem_waddr_o, mem_wdata_o;
   logic        mem_rena_o, reg_wena_o, mem_wena_o;
   logic [4:0]  reg_waddr_o;
   logic [1:0]  fsm_state;

   int n_checks = 0;
   int n_pass   = 0;

   mem_access #(.TIMEOUT(TIMEOUT), .TO_W(5)) dut (
      .clk_100MHz(clk_100MHz), .arst_n(arst_n), .hold_ena_i(hold_ena), .inst_i(inst),
      .mem_rena_i(mem_rena), .mem_wena_i(mem_wena), .mem_addr_i(mem_addr),
      .mem_wdata_i(mem_wdata), .reg_wena_i(reg_wena), .reg_wdata_i(reg_wdata),
      .reg_waddr_i(reg_waddr), .bus_req_o(bus_req), .bus_we_o(bus_we),
      .bus_addr_o(bus_addr), .bus_wdata_o(bus_wdata), .bus_be_o(bus_be),
      .bus_ack_i(bus_ack), .bus_rdata_i(bus_rdata), .hold_req_o(hold_req),
      .bus_err_o(bus_err), .misalign_o(misalign), .inst_o(inst_o),
      .mem_rena_o(mem_rena_o), .mem_rdata_o(mem_rdata_o), .mem_raddr_o(mem_raddr_o),
      .reg_wena_o(reg_wena_o), .reg_wdata_o(reg_wdata_o), .reg_waddr_o(reg_waddr_o),
      .mem_wena_o(mem_wena_o), .mem_waddr_o(mem_waddr_o), .mem_wdata_o(mem_wdata_o),
      .fsm_state(fsm_state)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: pick the addressed byte/halfword arithmetically, then extend.
   function automatic logic [31:0] model_load(input int f3, input logic [31:0] a, input logic [31:0] rd);
      int unsigned bv, hv;
      bv = (rd >> (8 * int'(a[1:0]))) & 32'hFF;
      hv = (rd >> (16 * int'(a[1]))) & 32'hFFFF;
      case (f3)
         0:       return (bv >= 128) ? 32'(bv + 32'hFFFF_FF00) : 32'(bv);
         1:       return (hv >= 32768) ? 32'(hv + 32'hFFFF_0000) : 32'(hv);
         4:       return 32'(bv);
         5:       return 32'(hv);
         default: return rd;
      endcase
   endfunction

   // Reference: each lane b is enabled if it belongs to the addressed unit; lane data repeats the unit.
   task automatic model_store(input int f3, input logic [31:0] a, input logic [31:0] wd,
                              output logic [3:0] be, output logic [31:0] data);
      for (int b = 0; b < 4; b++) begin
         if (f3 == 0) begin
            be[b] = (b == int'(a[1:0]));
            data[8*b +: 8] = wd[7:0];
         end else if (f3 == 1) begin
            be[b] = ((b / 2) == int'(a[1]));
            data[8*b +: 8] = wd[8*(b%2) +: 8];
         end else begin
            be[b] = 1'b1;
            data[8*b +: 8] = wd[8*b +: 8];
         end
      end
   endtask

   task automatic drive_idle();
      mem_rena = 0; mem_wena = 0; reg_wena = 0; bus_ack = 0; hold_ena = 0;
   endtask

   task automatic run_txn(input string name, input int f3, input bit is_st, input bit both,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                          input int ack_dly);
      logic [31:0] exp_ld, exp_data;
      logic [3:0]  exp_be;
      bit          mis, acked;
      int          hold_cnt, req_hi, cyc, exp_req;
      mis = 0;
`ifdef MEM_MISALIGN_CHK_EN
      mis = ((f3 == 1 || f3 == 5) && a[0]) || (f3 == 2 && a[1:0] != 2'b00);
`endif
      acked   = !mis && (ack_dly < TIMEOUT);
      exp_req = mis ? 0 : (acked ? ack_dly + 1 : TIMEOUT);
      exp_ld  = acked ? model_load(f3, a, rd) : 32'h0;
      model_store(f3, a, wd, exp_be, exp_data);

      @(negedge clk_100MHz);
      inst = $urandom; inst[14:12] = f3[2:0];
      mem_rena = !is_st || both; mem_wena = is_st;
      mem_addr = a; mem_wdata = wd;
      reg_wena = !is_st; reg_wdata = $urandom; reg_waddr = 5'($urandom);
      #1;
      hold_cnt = hold_req ? 1 : 0;
      req_hi = 0; cyc = 0;
      @(posedge clk_100MHz);
      if (!mis) begin
         while (cyc < TIMEOUT) begin
            @(negedge clk_100MHz);
            if (bus_req) req_hi++;
            if (hold_req) hold_cnt++;
            if (cyc == 0) begin
               n_checks++; if (bus_addr !== (a & 32'hFFFF_FFFC)) $display("FAIL %s bus_addr: got %h want %h", name, bus_addr, a & 32'hFFFF_FFFC); else n_pass++;
               n_checks++; if (bus_we !== is_st) $display("FAIL %s bus_we: got %b want %b", name, bus_we, is_st); else n_pass++;
               if (is_st) begin
                  n_checks++; if (bus_be !== exp_be) $display("FAIL %s bus_be: got %b want %b", name, bus_be, exp_be); else n_pass++;
                  n_checks++; if (bus_wdata !== exp_data) $display("FAIL %s bus_wdata: got %h want %h", name, bus_wdata, exp_data); else n_pass++;
               end
            end
            bus_ack = (cyc == ack_dly);
            bus_rdata = (cyc == ack_dly) ? rd : $urandom;
            @(posedge clk_100MHz);
            if (bus_ack) break;
            cyc++;
         end
      end

      @(negedge clk_100MHz);
      bus_ack = 0;
      if (hold_req) hold_cnt++;
      n_checks++; if (req_hi !== exp_req) $display("FAIL %s req_cycles: got %0d want %0d", name, req_hi, exp_req); else n_pass++;
      n_checks++; if (hold_cnt !== exp_req + 1) $display("FAIL %s hold_cycles: got %0d want %0d", name, hold_cnt, exp_req + 1); else n_pass++;
      n_checks++; if (bus_req !== 1'b0) $display("FAIL %s done_bus_req: got %b want 0", name, bus_req); else n_pass++;
      n_checks++; if (bus_err !== (!mis && !acked)) $display("FAIL %s bus_err: got %b want %b", name, bus_err, !mis && !acked); else n_pass++;
      n_checks++; if (misalign !== mis) $display("FAIL %s misalign: got %b want %b", name, misalign, mis); else n_pass++;
      if (!is_st) begin
         n_checks++; if (reg_wena_o !== acked) $display("FAIL %s reg_wena: got %b want %b", name, reg_wena_o, acked); else n_pass++;
         n_checks++; if (reg_wdata_o !== exp_ld) $display("FAIL %s reg_wdata: got %h want %h", name, reg_wdata_o, exp_ld); else n_pass++;
         n_checks++; if (mem_rdata_o !== exp_ld) $display("FAIL %s mem_rdata: got %h want %h", name, mem_rdata_o, exp_ld); else n_pass++;
         n_checks++; if (mem_raddr_o !== a) $display("FAIL %s mem_raddr: got %h want %h", name, mem_raddr_o, a); else n_pass++;
      end else begin
         if (acked || mis) begin
            n_checks++; if (mem_wena_o !== acked) $display("FAIL %s mem_wena: got %b want %b", name, mem_wena_o, acked); else n_pass++;
         end
         n_checks++; if (mem_waddr_o !== a) $display("FAIL %s mem_waddr: got %h want %h", name, mem_waddr_o, a); else n_pass++;
         n_checks++; if (mem_wdata_o !== wd) $display("FAIL %s mem_wdata: got %h want %h", name, mem_wdata_o, wd); else n_pass++;
      end
      drive_idle();
      @(negedge clk_100MHz);
      n_checks++; if ({bus_err, misalign} !== 2'b00) $display("FAIL %s pulse_width: got %b want 00", name, {bus_err, misalign}); else n_pass++;
      n_checks++; if (fsm_state !== 2'd0) $display("FAIL %s back_to_idle: got %0d want 0", name, fsm_state); else n_pass++;
   endtask

   task automatic test_reset();
      arst_n = 0; drive_idle(); inst = 0; mem_addr = 0; mem_wdata = 0;
      reg_wdata = 0; reg_waddr = 0; bus_rdata = 0;
      #23;
      n_checks++; if ({bus_req, bus_we, bus_err, misalign, hold_req} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {bus_req, bus_we, bus_err, misalign, hold_req}); else n_pass++;
      n_checks++; if ({bus_addr, bus_wdata, bus_be} !== 68'h0) $display("FAIL reset_payload: got %h want 0", {bus_addr, bus_wdata, bus_be}); else n_pass++;
      n_checks++; if (mem_rdata_o !== 32'h0) $display("FAIL reset_ld_data: got %h want 0", mem_rdata_o); else n_pass++;
      n_checks++; if (fsm_state !== 2'd0) $display("FAIL reset_state: got %0d want 0", fsm_state); else n_pass++;
      @(negedge clk_100MHz);
      arst_n = 1;
   endtask

   task automatic test_passthrough();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_100MHz);
         drive_idle();
         hold_ena = 1'($urandom); inst = $urandom; reg_wena = 1'($urandom);
         reg_wdata = $urandom; reg_waddr = 5'($urandom); mem_addr = $urandom;
         #1;
         n_checks++; if (hold_req !== 1'b0) $display("FAIL pass_hold: got %b want 0", hold_req); else n_pass++;
         n_checks++; if ({inst_o, reg_wdata_o, reg_waddr_o, reg_wena_o} !== {inst, reg_wdata, reg_waddr, reg_wena}) $display("FAIL pass_data: got %h want %h", {inst_o, reg_wdata_o, reg_waddr_o, reg_wena_o}, {inst, reg_wdata, reg_waddr, reg_wena}); else n_pass++;
      end
      drive_idle();
   endtask

   task automatic test_hold();
      // A system hold in IDLE blocks the request entirely.
      @(negedge clk_100MHz);
      inst = 0; inst[14:12] = 3'b010; mem_rena = 1; mem_addr = 32'h10; hold_ena = 1;
      #1;
      n_checks++; if (hold_req !== 1'b0) $display("FAIL hold_idle_req: got %b want 0", hold_req); else n_pass++;
      @(negedge clk_100MHz);
      n_checks++; if (bus_req !== 1'b0) $display("FAIL hold_idle_bus: got %b want 0", bus_req); else n_pass++;
      // A hold in DONE keeps the result visible.
      hold_ena = 0; reg_wena = 1;
      @(negedge clk_100MHz);
      bus_ack = 1; bus_rdata = 32'h1234_5678;
      @(negedge clk_100MHz);
      bus_ack = 0; hold_ena = 1;
      @(negedge clk_100MHz);
      @(negedge clk_100MHz);
      n_checks++; if (fsm_state !== 2'd2) $display("FAIL hold_done_state: got %0d want 2", fsm_state); else n_pass++;
      n_checks++; if (reg_wdata_o !== 32'h1234_5678) $display("FAIL hold_done_data: got %h want 12345678", reg_wdata_o); else n_pass++;
      n_checks++; if (hold_req !== 1'b0) $display("FAIL hold_done_hreq: got %b want 0", hold_req); else n_pass++;
      drive_idle();
      @(negedge clk_100MHz);
      n_checks++; if (fsm_state !== 2'd0) $display("FAIL hold_release: got %0d want 0", fsm_state); else n_pass++;
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk_100MHz);
      inst = 0; inst[14:12] = 3'b010; mem_rena = 1; reg_wena = 1; mem_addr = 32'h80;
      @(negedge clk_100MHz);
      n_checks++; if (bus_req !== 1'b1) $display("FAIL rst_mid_started: got %b want 1", bus_req); else n_pass++;
      drive_idle();
      #2 arst_n = 0;
      #1;
      n_checks++; if (bus_req !== 1'b0) $display("FAIL rst_mid_bus_req: got %b want 0", bus_req); else n_pass++;
      n_checks++; if (fsm_state !== 2'd0) $display("FAIL rst_mid_state: got %0d want 0", fsm_state); else n_pass++;
      @(negedge clk_100MHz);
      arst_n = 1;
      run_txn("rst_then_sw", 2, 1, 0, 32'h40, 32'hCAFE_F00D, 32'h0, 1);
   endtask

   task automatic test_random();
      int f3, r, dly;
      bit st;
      for (int i = 0; i < 40; i++) begin
         st = 1'($urandom_range(0, 1));
         f3 = st ? $urandom_range(0, 2) : $urandom_range(0, 7);
         r = $urandom_range(0, 9);
         dly = (r < 7) ? r % 4 : (r == 7) ? TIMEOUT - 1 : (r == 8) ? TIMEOUT + 2 : 0;
         run_txn("random", f3, st, 1'($urandom_range(0, 1)) & st, $urandom, $urandom, $urandom, dly);
      end
   endtask

   initial begin
      test_reset();
      run_txn("lb_0x103", 0, 0, 0, 32'h103, 32'h0, 32'h80FF_1234, 0);
      run_txn("lhu_0x202", 5, 0, 0, 32'h202, 32'h0, 32'hBEEF_0000, 2);
      run_txn("sb_0x301", 0, 1, 0, 32'h301, 32'h0000_00A5, 32'h0, 0);
      run_txn("sh_0x302", 1, 1, 0, 32'h302, 32'h1234_BEEF, 32'h0, 1);
      run_txn("lh_neg", 1, 0, 0, 32'h500, 32'h0, 32'h0000_8001, 0);
      run_txn("lw_timeout", 2, 0, 0, 32'h600, 32'h0, 32'h0, TIMEOUT + 5);
      run_txn("lw_ack_at_limit", 2, 0, 0, 32'h604, 32'h0, 32'hA5A5_0F0F, TIMEOUT - 1);
      run_txn("store_wins", 2, 1, 1, 32'h700, 32'h0BAD_BEEF, 32'h0, 0);
      run_txn("lw_0x41", 2, 0, 0, 32'h41, 32'h0, 32'h7654_3210, 0);
      test_passthrough();
      test_hold();
      test_reset_mid_access();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
